// File: rtl/watch_pkg.sv
// Shared widths, field limits and the adjust-select encoding for the watch-mode
// timekeeping datapath.
package watch_pkg;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int ADJ_N  = 12;

  localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  // Encoding: bit0 = inc (else dec), bit1 = tens digit, bits[3:2] = field
  // (0 sec, 1 min, 2 hour). Higher value means higher priority.
  typedef enum logic [3:0] {
    ADJ_DEC_SEC_1   = 4'd0,
    ADJ_INC_SEC_1   = 4'd1,
    ADJ_DEC_SEC_10  = 4'd2,
    ADJ_INC_SEC_10  = 4'd3,
    ADJ_DEC_MIN_1   = 4'd4,
    ADJ_INC_MIN_1   = 4'd5,
    ADJ_DEC_MIN_10  = 4'd6,
    ADJ_INC_MIN_10  = 4'd7,
    ADJ_DEC_HOUR_1  = 4'd8,
    ADJ_INC_HOUR_1  = 4'd9,
    ADJ_DEC_HOUR_10 = 4'd10,
    ADJ_INC_HOUR_10 = 4'd11
  } adj_sel_e;

endpackage

// File: rtl/watch_tick_gen.sv
// Centisecond prescaler: counts only while enabled and holds (not clears) when
// disabled so a stopped second resumes exactly where it left off.
module watch_tick_gen #(
  parameter int CLKS_PER_CS = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic cs_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_CS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_CS - 1);

  logic [CNT_W-1:0] cnt;

  assign cs_tick = en && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cs_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/watch_time_datapath.sv
// Watch-mode time datapath: running hh:mm:ss.cc cascade plus stopped-mode
// digit edits driven by edge-detected adjust pulses.
module watch_time_datapath
  import watch_pkg::*;
#(
  parameter int CLKS_PER_CS = 1_000_000,
  parameter int INIT_HOUR   = 12,
  parameter int INIT_MIN    = 0,
  parameter int INIT_SEC    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_stop,
  input  logic              inc_sec_1,
  input  logic              dec_sec_1,
  input  logic              inc_sec_10,
  input  logic              dec_sec_10,
  input  logic              inc_min_1,
  input  logic              dec_min_1,
  input  logic              inc_min_10,
  input  logic              dec_min_10,
  input  logic              inc_hour_1,
  input  logic              dec_hour_1,
  input  logic              inc_hour_10,
  input  logic              dec_hour_10,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_sec_tick
);

  logic              cs_tick;
  logic [ADJ_N-1:0]  adj_in, adj_prev, adj_rise;
  logic              adj_vld;
  adj_sel_e          adj_sel;
  logic [MSEC_W-1:0] msec;
  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic              sec_tick;

  // Sec and min share the 0..59 rules; edits never carry into other fields.
  function automatic logic [SEC_W-1:0] adj_60(input logic [SEC_W-1:0] v,
                                              input logic inc, input logic ten);
    logic [SEC_W-1:0] r;
    if (ten) r = inc ? ((v >= 6'd50) ? v - 6'd50 : v + 6'd10)
                     : ((v < 6'd10)  ? v + 6'd50 : v - 6'd10);
    else     r = inc ? ((v == SEC_MAX) ? '0 : v + 6'd1)
                     : ((v == '0) ? SEC_MAX : v - 6'd1);
    return r;
  endfunction

  // Hour tens digit rotates 0->1->2->0, skipping any result above 23.
  function automatic logic [HOUR_W-1:0] adj_24(input logic [HOUR_W-1:0] v,
                                               input logic inc, input logic ten);
    logic [HOUR_W-1:0] r;
    if (ten && inc)      r = (v <= 5'd13) ? v + 5'd10 : ((v >= 5'd20) ? v - 5'd20 : v - 5'd10);
    else if (ten)        r = (v >= 5'd10) ? v - 5'd10 : ((v <= 5'd3) ? v + 5'd20 : v + 5'd10);
    else if (inc)        r = (v == HOUR_MAX) ? '0 : v + 5'd1;
    else                 r = (v == '0) ? HOUR_MAX : v - 5'd1;
    return r;
  endfunction

  watch_tick_gen #(.CLKS_PER_CS(CLKS_PER_CS)) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (run_stop),
    .cs_tick (cs_tick)
  );

  assign adj_in = {inc_hour_10, dec_hour_10, inc_hour_1, dec_hour_1,
                   inc_min_10,  dec_min_10,  inc_min_1,  dec_min_1,
                   inc_sec_10,  dec_sec_10,  inc_sec_1,  dec_sec_1};
  assign adj_rise = adj_in & ~adj_prev;

  always_comb begin
    adj_vld = 1'b0;
    adj_sel = ADJ_DEC_SEC_1;
    for (int i = 0; i < ADJ_N; i++) begin
      if (adj_rise[i]) begin
        adj_vld = 1'b1;
        adj_sel = adj_sel_e'(4'(i));
      end
    end
  end

  // Single register stage: cascade while running, one edit while stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      adj_prev <= '0;
      msec     <= '0;
      sec      <= SEC_W'(INIT_SEC);
      min      <= MIN_W'(INIT_MIN);
      hour     <= HOUR_W'(INIT_HOUR);
      sec_tick <= 1'b0;
    end else begin
      adj_prev <= adj_in;
      sec_tick <= cs_tick && (msec == MSEC_MAX);
      if (cs_tick) begin
        if (msec == MSEC_MAX) begin
          msec <= '0;
          if (sec == SEC_MAX) begin
            sec <= '0;
            if (min == MIN_MAX) begin
              min  <= '0;
              hour <= (hour == HOUR_MAX) ? '0 : hour + 1'b1;
            end else begin
              min <= min + 1'b1;
            end
          end else begin
            sec <= sec + 1'b1;
          end
        end else begin
          msec <= msec + 1'b1;
        end
      end else if (!run_stop && adj_vld) begin
        case (adj_sel[3:2])
          2'd0:    sec  <= adj_60(sec, adj_sel[0], adj_sel[1]);
          2'd1:    min  <= adj_60(min, adj_sel[0], adj_sel[1]);
          default: hour <= adj_24(hour, adj_sel[0], adj_sel[1]);
        endcase
      end
    end
  end

  assign o_msec     = msec;
  assign o_sec      = sec;
  assign o_min      = min;
  assign o_hour     = hour;
  assign o_sec_tick = sec_tick;

endmodule

// File: tb/tb_watch_time_datapath.sv
// Bench for watch_time_datapath: directed scenarios plus randomized stimulus,
// all compared against a total-centisecond reference model.
module tb_watch_time_datapath;

  localparam int CPC = 4;
  localparam int DAY = 24 * 60 * 60 * 100;
  localparam int INIT_TM = 12 * 360000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_stop = 1'b0;
  logic [11:0] adj = '0;
  logic [6:0]  o_msec;
  logic [5:0]  o_sec;
  logic [5:0]  o_min;
  logic [4:0]  o_hour;
  logic        o_sec_tick;

  int checks = 0;
  int failures = 0;

  int          m_pc = 0;
  int          m_tm = INIT_TM;
  int          m_tick = 0;
  logic [11:0] m_prev = '0;

  watch_time_datapath #(
    .CLKS_PER_CS(CPC), .INIT_HOUR(12), .INIT_MIN(0), .INIT_SEC(0)
  ) dut (
    .clk(clk), .rst(rst), .run_stop(run_stop),
    .inc_sec_1(adj[1]),   .dec_sec_1(adj[0]),
    .inc_sec_10(adj[3]),  .dec_sec_10(adj[2]),
    .inc_min_1(adj[5]),   .dec_min_1(adj[4]),
    .inc_min_10(adj[7]),  .dec_min_10(adj[6]),
    .inc_hour_1(adj[9]),  .dec_hour_1(adj[8]),
    .inc_hour_10(adj[11]), .dec_hour_10(adj[10]),
    .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_sec_tick(o_sec_tick)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hour_tens(input int v, input bit up);
    int t, o, nt;
    t = v / 10;
    o = v % 10;
    for (int k = 1; k <= 2; k++) begin
      nt = up ? (t + k) % 3 : (t + 3 - k) % 3;
      if (nt * 10 + o <= 23) return nt * 10 + o;
    end
    return v;
  endfunction

  function automatic int apply_edit(input int tm, input int b);
    int cs, s, m, h, v, lim, f, op;
    cs = tm % 100; s = (tm / 100) % 60; m = (tm / 6000) % 60; h = tm / 360000;
    f = b / 4; op = b % 4;
    v = (f == 0) ? s : (f == 1) ? m : h;
    lim = (f == 2) ? 24 : 60;
    case (op)
      0: v = (v + lim - 1) % lim;
      1: v = (v + 1) % lim;
      2: v = (f == 2) ? hour_tens(v, 1'b0) : (v + 50) % 60;
      default: v = (f == 2) ? hour_tens(v, 1'b1) : (v + 10) % 60;
    endcase
    if (f == 0) s = v; else if (f == 1) m = v; else h = v;
    return ((h * 60 + m) * 60 + s) * 100 + cs;
  endfunction

  always @(posedge clk) begin
    logic [11:0] rise;
    int old_s, b;
    if (rst) begin
      m_pc = 0; m_tm = INIT_TM; m_tick = 0; m_prev = '0;
    end else begin
      rise = adj & ~m_prev;
      m_prev = adj;
      m_tick = 0;
      if (run_stop) begin
        if (m_pc == CPC - 1) begin
          m_pc = 0;
          old_s = (m_tm / 100) % 60;
          m_tm = (m_tm + 1) % DAY;
          if ((m_tm / 100) % 60 != old_s) m_tick = 1;
        end else begin
          m_pc++;
        end
      end else if (rise != '0) begin
        b = 0;
        for (int i = 0; i < 12; i++) if (rise[i]) b = i;
        m_tm = apply_edit(m_tm, b);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    check_val("msec", o_msec, m_tm % 100);
    check_val("sec",  o_sec,  (m_tm / 100) % 60);
    check_val("min",  o_min,  (m_tm / 6000) % 60);
    check_val("hour", o_hour, m_tm / 360000);
    check_val("sec_tick", o_sec_tick, m_tick);
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int b, input int n);
    repeat (n) begin
      adj[b] = 1'b1; step();
      adj[b] = 1'b0; step();
    end
  endtask

  initial begin
    int ticks, n, h0, s0, m0;
    bit found;

    cycles(2);
    check_val("rst_msec", o_msec, 0);
    check_val("rst_sec",  o_sec, 0);
    check_val("rst_min",  o_min, 0);
    check_val("rst_hour", o_hour, 12);
    check_val("rst_tick", o_sec_tick, 0);

    rst = 1'b0; run_stop = 1'b1; ticks = 0;
    repeat (400) begin
      step();
      if (o_sec_tick) ticks++;
    end
    check_val("run_ticks", ticks, 1);
    check_val("run_msec", o_msec, 0);
    check_val("run_sec", o_sec, 1);
    check_val("run_hour", o_hour, 12);

    run_stop = 1'b0; step();
    pulse(8, 13); pulse(4, 1); pulse(0, 2);
    check_val("pre_hour", o_hour, 23);
    check_val("pre_min", o_min, 59);
    check_val("pre_sec", o_sec, 59);
    run_stop = 1'b1;
    cycles(400);
    check_val("wrap_hour", o_hour, 0);
    check_val("wrap_min", o_min, 0);
    check_val("wrap_sec", o_sec, 0);
    check_val("wrap_msec", o_msec, 0);

    run_stop = 1'b0; step();
    pulse(0, 5);
    check_val("sec55", o_sec, 55);
    adj[3] = 1'b1; step();
    check_val("sec10_wrap", o_sec, 5);
    adj[3] = 1'b0; step();
    pulse(2, 1); pulse(1, 5);
    check_val("sec00", o_sec, 0);
    pulse(0, 1);
    check_val("sec_dec_wrap", o_sec, 59);

    pulse(11, 1); pulse(9, 4);
    check_val("hour14", o_hour, 14);
    pulse(11, 1);
    check_val("hour14_inc10", o_hour, 4);
    pulse(9, 1); pulse(10, 1);
    check_val("hour05_dec10", o_hour, 15);
    pulse(10, 1); pulse(8, 3);
    check_val("hour02", o_hour, 2);
    pulse(10, 1);
    check_val("hour02_dec10", o_hour, 22);

    m0 = o_min;
    adj[5] = 1'b1; cycles(10); adj[5] = 1'b0; step();
    check_val("min_hold", o_min, (m0 + 1) % 60);

    s0 = o_sec;
    run_stop = 1'b1; step();
    adj[1] = 1'b1; step(); adj[1] = 1'b0; step();
    check_val("run_edit_ignored", o_sec, s0);
    run_stop = 1'b0; step();

    h0 = o_hour; s0 = o_sec;
    adj[9] = 1'b1; adj[0] = 1'b1; step();
    check_val("prio_hour", o_hour, (h0 + 1) % 24);
    check_val("prio_sec", o_sec, s0);
    adj = '0; step();

    rst = 1'b1; step(); rst = 1'b0; run_stop = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (o_msec == 7'd37) found = 1'b1;
    end
    check_val("reach37", found, 1);
    run_stop = 1'b0; cycles(50);
    check_val("hold37", o_msec, 37);
    run_stop = 1'b1; n = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(); n++;
      if (o_msec == 7'd38) found = 1'b1;
    end
    check_val("resume38", found, 1);
    check_val("resume_lat", n, CPC);
    cycles(2);
    rst = 1'b1; step();
    check_val("mid_rst_hour", o_hour, 12);
    check_val("mid_rst_min", o_min, 0);
    check_val("mid_rst_sec", o_sec, 0);
    check_val("mid_rst_msec", o_msec, 0);
    rst = 1'b0;

    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) run_stop = ~run_stop;
      for (int i = 0; i < 12; i++) adj[i] = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 1'b0; adj = '0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
